mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Clock and reset SHALL be one clock and one reset; reset is asynchronous and active-low.
REQ-002 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n_i  input  1  asynchronous active-low reset.
REQ-004 req_valid_i  input  1  MEM stage presents a memory operation this cycle.
REQ-005 MemRead_i  input  1  operation is a load.
REQ-006 MemWrite_i  input  1  operation is a store; has priority over MemRead_i if both are high.
REQ-007 funct3_i  input  3  000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu for loads; 000 sb, 001 sh, 010 sw for stores; other codes are treated as word.
REQ-008 addr_i  input  32  byte address.
REQ-009 data_i  input  32  store data; low byte or halfword is used for sb/sh.
REQ-010 data_o  output  32  load result, extended to 32 bits.
REQ-011 stall_o  output  1  freeze the pipeline.
REQ-012 misalign_o  output  1  one-cycle pulse flagging a misaligned access.
REQ-013 mem_addr_o  output  32  word address, always addr_i with bits [1:0] forced to 0.
REQ-014 mem_read_o / mem_write_o  output  1 each  word read / word write request to the data memory.
REQ-015 mem_wdata_o  output  32  full word written.
REQ-016 mem_rdata_i  input  32  read word, valid when mem_ready_i is high.
REQ-017 mem_ready_i  input  1  memory accepts or completes the current request.

Function
REQ-018 FSM states SHALL be IDLE, RD, WR, DONE; byte order is little-endian (byte n = bits 8n+7:8n).
REQ-019 IDLE: when req_valid_i is high and the access is aligned, stall_o SHALL be 1 combinationally; next state is RD for loads, sb and sh, and WR for sw.
REQ-020 RD SHALL drive mem_read_o=1 and hold mem_addr_o stable until mem_ready_i; on mem_ready_i it captures mem_rdata_i. Next state is WR for sb/sh, otherwise DONE.
REQ-021 sb/sh SHALL merge the captured word with the byte or halfword of data_i at lane addr_i[1:0] (halfword lane addr_i[1]); the merged word is presented on mem_wdata_o in WR.
REQ-022 WR SHALL drive mem_write_o=1 with stable address and data until mem_ready_i, then go to DONE.
REQ-023 DONE SHALL set stall_o=0 and hold data_o valid for loads; the next state is unconditionally IDLE, so a request is never reissued.
REQ-024 Load extraction: lb/lh sign-extend and lbu/lhu zero-extend the selected lane; lw passes the word unchanged.
REQ-025 Misalignment is lh/lhu/sh with addr_i[0]=1, or lw/sw with addr_i[1:0]!=0.
REQ-026 On misalignment in IDLE, the unit SHALL pulse misalign_o for one cycle, keep stall_o=0 and data_o=0, issue no memory request, and stay in IDLE.
REQ-027 mem_read_o and mem_write_o SHALL never be high in the same cycle.
REQ-028 Latency with mem_ready_i tied high: lw/lb/sw take 3 cycles (stall_o high for 2), sb/sh take 4 cycles; each wait cycle on mem_ready_i adds one cycle.
REQ-029 req_valid_i=0, or MemRead_i=MemWrite_i=0, in IDLE SHALL produce no request and stall_o=0.
REQ-030 data_o SHALL be 0 outside DONE for loads.

Reset
REQ-031 rst_n_i low SHALL immediately force state IDLE and drive all outputs and internal registers to 0, including mid-RD and mid-WR; an aborted write is not completed.
REQ-032 After rst_n_i deasserts, the first accepted request SHALL behave as from a clean IDLE.

Structure
REQ-033 A shared package mem_pkg SHALL hold the funct3 size constants and the state enumeration.
REQ-034 Lane extraction/extension and store merge SHALL reside in one combinational sub-module, lsu_byte_lane; the FSM stays in mem_access_unit.

Verification
REQ-035 lw at 0x10, rdata 0xDEADBEEF, ready high -> mem_read_o=1 with mem_addr_o 0x10 in cycle 1, data_o 0xDEADBEEF with stall_o=0 in cycle 2.
REQ-036 lb at 0x13 with rdata 0x80123456 -> data_o 0xFFFFFF80; lbu at the same address -> 0x00000080; lh at 0x12 -> 0xFFFF8012.
REQ-037 sb at 0x21, data_i 0x000000AB, old word 0x11223344 -> read at 0x20, then mem_wdata_o 0x1122AB44 at 0x20, stall_o high for 3 cycles.
REQ-038 lw at 0x06 and sh at 0x03 -> misalign_o single pulse, no mem_read_o/mem_write_o, stall_o=0.
REQ-039 sw with mem_ready_i delayed 3 cycles -> mem_write_o, mem_addr_o and mem_wdata_o stable throughout, and stall_o held until DONE.
REQ-040 rst_n_i asserted during WR -> mem_write_o falls asynchronously, the FSM is in IDLE, and the next lw completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: constants and types shared by the memory access unit.
//   - funct3 access-size codes for loads and stores
//   - mem_state_t: access sequencer states (IDLE, RD, WR, DONE)
//   - is_misaligned(): alignment rule for a given access
//   - is_rmw_store(): stores that need a read-modify-write (sb/sh)
package mem_pkg;

  localparam logic [2:0] F3_BYTE   = 3'b000;
  localparam logic [2:0] F3_HALF   = 3'b001;
  localparam logic [2:0] F3_WORD   = 3'b010;
  localparam logic [2:0] F3_BYTE_U = 3'b100;
  localparam logic [2:0] F3_HALF_U = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    DONE = 2'b11
  } mem_state_t;

  // Stores only know sb/sh/sw; any other store code is a word access.
  // Loads additionally know lbu/lhu; any other load code is a word access.
  function automatic logic is_misaligned(input logic       is_store,
                                         input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    if (is_store) begin
      case (funct3)
        F3_BYTE: mis = 1'b0;
        F3_HALF: mis = addr_lo[0];
        default: mis = (addr_lo != 2'b00);
      endcase
    end else begin
      case (funct3)
        F3_BYTE, F3_BYTE_U: mis = 1'b0;
        F3_HALF, F3_HALF_U: mis = addr_lo[0];
        default:            mis = (addr_lo != 2'b00);
      endcase
    end
    return mis;
  endfunction

  // Sub-word stores must read the old word first so the other lanes survive.
  function automatic logic is_rmw_store(input logic [2:0] funct3);
    return (funct3 == F3_BYTE) || (funct3 == F3_HALF);
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// lsu_byte_lane: combinational byte-lane datapath (little-endian).
// Ports:
//   i_funct3      access size code
//   i_lane        byte offset within the word (halfword lane = i_lane[1])
//   i_word        word read from memory
//   i_store_data  store data; low byte/halfword used for sb/sh
//   o_load_data   selected lane, sign- or zero-extended (word passes through)
//   o_merge_data  i_word with the store lane replaced (full store data for sw)
module lsu_byte_lane
  import mem_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_word,
  input  logic [31:0] i_store_data,
  output logic [31:0] o_load_data,
  output logic [31:0] o_merge_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Select the addressed byte and halfword of the read word.
  always_comb begin
    w_byte = 8'h00;
    case (i_lane)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      2'd3:    w_byte = i_word[31:24];
      default: w_byte = 8'h00;
    endcase
    w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];
  end

  // Extend the selected lane to 32 bits for the load result.
  always_comb begin
    o_load_data = 32'h0000_0000;
    case (i_funct3)
      F3_BYTE:   o_load_data = {{24{w_byte[7]}}, w_byte};
      F3_BYTE_U: o_load_data = {24'h00_0000, w_byte};
      F3_HALF:   o_load_data = {{16{w_half[15]}}, w_half};
      F3_HALF_U: o_load_data = {16'h0000, w_half};
      F3_WORD:   o_load_data = i_word;
      default:   o_load_data = i_word;
    endcase
  end

  // Insert the store byte/halfword into the old word; word stores replace it all.
  always_comb begin
    o_merge_data = i_word;
    case (i_funct3)
      F3_BYTE: begin
        case (i_lane)
          2'd0:    o_merge_data[7:0]   = i_store_data[7:0];
          2'd1:    o_merge_data[15:8]  = i_store_data[7:0];
          2'd2:    o_merge_data[23:16] = i_store_data[7:0];
          2'd3:    o_merge_data[31:24] = i_store_data[7:0];
          default: o_merge_data        = i_word;
        endcase
      end
      F3_HALF: begin
        if (i_lane[1]) begin
          o_merge_data[31:16] = i_store_data[15:0];
        end else begin
          o_merge_data[15:0] = i_store_data[15:0];
        end
      end
      default: o_merge_data = i_store_data;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store sequencer in front of a word-wide
// data memory. Sub-word stores are done as read-modify-write.
// Ports:
//   clk_i, rst_n_i            clock, asynchronous active-low reset
//   req_valid_i               MEM stage presents an operation
//   MemRead_i / MemWrite_i    load / store (store wins if both)
//   funct3_i, addr_i, data_i  size code, byte address, store data
//   data_o                    extended load result (valid in DONE only)
//   stall_o                   freeze the pipeline while the access runs
//   misalign_o                one-cycle flag for a rejected misaligned access
//   mem_addr_o, mem_read_o, mem_write_o, mem_wdata_o   word request to memory
//   mem_rdata_i, mem_ready_i  read word / request accepted or completed
module mem_access_unit
  import mem_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_valid_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        stall_o,
  output logic        misalign_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ready_i
);

  mem_state_t  r_state;
  mem_state_t  w_next_state;

  // Request captured on acceptance so address/data stay stable while stalled.
  logic [2:0]  r_funct3;
  logic [1:0]  r_lane;
  logic [29:0] r_waddr;
  logic [31:0] r_sdata;
  logic        r_is_store;
  logic [31:0] r_rdata;

  logic        w_req;
  logic        w_mis;
  logic        w_accept;
  logic [31:0] w_load_data;
  logic [31:0] w_merge_data;

  // The combinational IDLE outputs are gated by rst_n_i so they are 0 in reset.
  assign w_req    = rst_n_i & req_valid_i & (MemRead_i | MemWrite_i) & (r_state == IDLE);
  assign w_mis    = is_misaligned(MemWrite_i, funct3_i, addr_i[1:0]);
  assign w_accept = w_req & ~w_mis;

  lsu_byte_lane u_lane (
    .i_funct3     (r_funct3),
    .i_lane       (r_lane),
    .i_word       (r_rdata),
    .i_store_data (r_sdata),
    .o_load_data  (w_load_data),
    .o_merge_data (w_merge_data)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Capture the accepted request and the word returned by the read.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_funct3   <= 3'b000;
      r_lane     <= 2'b00;
      r_waddr    <= 30'h0000_0000;
      r_sdata    <= 32'h0000_0000;
      r_is_store <= 1'b0;
      r_rdata    <= 32'h0000_0000;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_funct3   <= funct3_i;
            r_lane     <= addr_i[1:0];
            r_waddr    <= addr_i[31:2];
            r_sdata    <= data_i;
            r_is_store <= MemWrite_i;
          end
        end
        RD: begin
          if (mem_ready_i) begin
            r_rdata <= mem_rdata_i;
          end
        end
        default: begin
          r_rdata <= r_rdata;
        end
      endcase
    end
  end

  // Next-state and output decode.
  always_comb begin
    w_next_state = r_state;
    stall_o      = 1'b0;
    misalign_o   = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = 32'h0000_0000;
    mem_wdata_o  = 32'h0000_0000;
    data_o       = 32'h0000_0000;
    case (r_state)
      IDLE: begin
        if (w_req && w_mis) begin
          misalign_o   = 1'b1;
          w_next_state = IDLE;
        end else if (w_accept) begin
          stall_o = 1'b1;
          // Word stores need no read; everything else starts with one.
          if (MemWrite_i && !is_rmw_store(funct3_i)) begin
            w_next_state = WR;
          end else begin
            w_next_state = RD;
          end
        end else begin
          w_next_state = IDLE;
        end
      end
      RD: begin
        stall_o    = 1'b1;
        mem_read_o = 1'b1;
        mem_addr_o = {r_waddr, 2'b00};
        if (mem_ready_i) begin
          w_next_state = r_is_store ? WR : DONE;
        end else begin
          w_next_state = RD;
        end
      end
      WR: begin
        stall_o     = 1'b1;
        mem_write_o = 1'b1;
        mem_addr_o  = {r_waddr, 2'b00};
        mem_wdata_o = w_merge_data;
        if (mem_ready_i) begin
          w_next_state = DONE;
        end else begin
          w_next_state = WR;
        end
      end
      DONE: begin
        // Unconditional return to IDLE: the stalled request is never reissued.
        w_next_state = IDLE;
        data_o       = r_is_store ? 32'h0000_0000 : w_load_data;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk_i;
  logic        rst_n_i;
  logic        req_valid_i;
  logic        MemRead_i;
  logic        MemWrite_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        stall_o;
  logic        misalign_o;
  logic [31:0] mem_addr_o;
  logic        mem_read_o;
  logic        mem_write_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ready_i;

  mem_access_unit dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .req_valid_i (req_valid_i),
    .MemRead_i   (MemRead_i),
    .MemWrite_i  (MemWrite_i),
    .funct3_i    (funct3_i),
    .addr_i      (addr_i),
    .data_i      (data_i),
    .data_o      (data_o),
    .stall_o     (stall_o),
    .misalign_o  (misalign_o),
    .mem_addr_o  (mem_addr_o),
    .mem_read_o  (mem_read_o),
    .mem_write_o (mem_write_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ready_i (mem_ready_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        stall;
    logic        rd;
    logic        wr;
    logic        mis;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] data;
  } exp_t;

  exp_t        e;
  logic        chk_en;
  int          n_cmp;
  int          n_err;
  int          n_stall;
  int          n_mis;
  logic [31:0] got_data;
  logic [31:0] got_wdata;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle compare of every DUT output against the expected cycle.
  always @(negedge clk_i) begin
    if (chk_en) begin
      check("stall_o",     {31'd0, stall_o},     {31'd0, e.stall});
      check("mem_read_o",  {31'd0, mem_read_o},  {31'd0, e.rd});
      check("mem_write_o", {31'd0, mem_write_o}, {31'd0, e.wr});
      check("misalign_o",  {31'd0, misalign_o},  {31'd0, e.mis});
      check("mem_addr_o",  mem_addr_o,  e.addr);
      check("mem_wdata_o", mem_wdata_o, e.wdata);
      check("data_o",      data_o,      e.data);
      check("rd_wr_excl",  {31'd0, mem_read_o & mem_write_o}, 32'd0);
    end
  end

  // ---------------- behavioural model ----------------
  function automatic int size_of(input logic st, input logic [2:0] f3);
    if (st) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    return (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] v;
    v = w >> (8 * int'(a[1:0]));
    if (f3 == 3'd0) begin
      v = v & 32'h0000_00FF;
      if (v[7]) v = v | 32'hFFFF_FF00;
    end else if (f3 == 3'd4) begin
      v = v & 32'h0000_00FF;
    end else if (f3 == 3'd1) begin
      v = v & 32'h0000_FFFF;
      if (v[15]) v = v | 32'hFFFF_0000;
    end else if (f3 == 3'd5) begin
      v = v & 32'h0000_FFFF;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] m_merge(input int sz, input logic [31:0] a,
                                          input logic [31:0] old, input logic [31:0] sd);
    logic [31:0] mask;
    int sh;
    mask = (sz == 1) ? 32'h0000_00FF : (sz == 2) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    sh   = 8 * int'(a[1:0]);
    return (old & ~(mask << sh)) | ((sd & mask) << sh);
  endfunction

  // Present one cycle: set inputs/expectation after the edge, sample at negedge.
  task automatic cycle_set(input exp_t x, input logic rdy, input logic cap);
    mem_ready_i = rdy;
    e           = x;
    chk_en      = 1'b1;
    @(negedge clk_i);
    n_stall = n_stall + int'(stall_o);
    n_mis   = n_mis + int'(misalign_o);
    if (cap) got_data = data_o;
    if (x.wr) got_wdata = mem_wdata_o;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_cycle();
    exp_t z;
    z = '0;
    req_valid_i = 1'b0;
    MemRead_i   = 1'b0;
    MemWrite_i  = 1'b0;
    cycle_set(z, 1'b0, 1'b0);
  endtask

  // Expand one request into its expected cycle-by-cycle timeline.
  task automatic run_op(input logic st, input logic both, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd, input logic [31:0] old,
                        input int rdl, input int wdl);
    exp_t x;
    int sz;
    logic [31:0] wa;
    sz = size_of(st, f3);
    wa = a & 32'hFFFF_FFFC;
    n_stall = 0;
    n_mis   = 0;
    req_valid_i = 1'b1;
    MemWrite_i  = st;
    MemRead_i   = ~st | both;
    funct3_i    = f3;
    addr_i      = a;
    data_i      = sd;
    mem_rdata_i = old;
    x = '0;
    if ((int'(a[1:0]) % sz) != 0) begin
      x.mis = 1'b1;
      cycle_set(x, 1'b0, 1'b0);
    end else begin
      x.stall = 1'b1;
      cycle_set(x, 1'b0, 1'b0);
      if (!st || sz < 4) begin
        for (int k = 0; k <= rdl; k++) begin
          x = '0; x.stall = 1'b1; x.rd = 1'b1; x.addr = wa;
          cycle_set(x, (k == rdl), 1'b0);
        end
      end
      if (st) begin
        for (int k = 0; k <= wdl; k++) begin
          x = '0; x.stall = 1'b1; x.wr = 1'b1; x.addr = wa;
          x.wdata = m_merge(sz, a, old, sd);
          cycle_set(x, (k == wdl), 1'b0);
        end
      end
      x = '0;
      x.data = st ? 32'h0 : m_load(f3, a, old);
      cycle_set(x, 1'b0, 1'b1);
    end
    idle_cycle();
  endtask

  exp_t z0;

  initial begin
    n_cmp = 0; n_err = 0; n_stall = 0; n_mis = 0;
    got_data = 32'h0; got_wdata = 32'h0;
    rst_n_i = 1'b0; req_valid_i = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0;
    funct3_i = 3'b000; addr_i = 32'h0; data_i = 32'h0;
    mem_rdata_i = 32'h0; mem_ready_i = 1'b0;
    z0 = '0;
    e = '0;
    chk_en = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    idle_cycle();

    // lw, ready high
    run_op(1'b0, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0);
    check("lw_lit", got_data, 32'hDEADBEEF);
    check("lw_stall_cycles", n_stall, 32'd2);
    // sub-word loads
    run_op(1'b0, 1'b0, 3'b000, 32'h13, 32'h0, 32'h80123456, 0, 0);
    check("lb_lit", got_data, 32'hFFFFFF80);
    check("lb_stall_cycles", n_stall, 32'd2);
    run_op(1'b0, 1'b0, 3'b100, 32'h13, 32'h0, 32'h80123456, 0, 0);
    check("lbu_lit", got_data, 32'h00000080);
    run_op(1'b0, 1'b0, 3'b001, 32'h12, 32'h0, 32'h80123456, 0, 0);
    check("lh_lit", got_data, 32'hFFFF8012);
    run_op(1'b0, 1'b0, 3'b101, 32'h12, 32'h0, 32'h80123456, 0, 0);
    check("lhu_lit", got_data, 32'h00008012);
    run_op(1'b0, 1'b0, 3'b000, 32'h11, 32'h0, 32'h80123456, 1, 0);
    check("lb_lane1_lit", got_data, 32'h00000034);
    run_op(1'b0, 1'b0, 3'b001, 32'h10, 32'h0, 32'h80123456, 2, 0);
    check("lh_lane0_wait_lit", got_data, 32'h00003456);
    check("lh_wait_stall_cycles", n_stall, 32'd4);
    run_op(1'b0, 1'b0, 3'b011, 32'h48, 32'h0, 32'h0BADF00D, 0, 0);
    // sub-word stores
    run_op(1'b1, 1'b0, 3'b000, 32'h21, 32'h000000AB, 32'h11223344, 0, 0);
    check("sb_merge_lit", got_wdata, 32'h1122AB44);
    check("sb_stall_cycles", n_stall, 32'd3);
    run_op(1'b1, 1'b0, 3'b001, 32'h22, 32'h5555BEEF, 32'h11223344, 1, 1);
    check("sh_merge_lit", got_wdata, 32'hBEEF3344);
    // word stores, delayed ready, store priority, other codes as word
    run_op(1'b1, 1'b0, 3'b010, 32'h30, 32'hCAFEF00D, 32'h0, 0, 3);
    check("sw_wdata_lit", got_wdata, 32'hCAFEF00D);
    check("sw_wait_stall_cycles", n_stall, 32'd5);
    run_op(1'b1, 1'b1, 3'b010, 32'h50, 32'h01020304, 32'hFFFFFFFF, 0, 0);
    check("sw_prio_stall_cycles", n_stall, 32'd2);
    run_op(1'b1, 1'b0, 3'b100, 32'h44, 32'h89ABCDEF, 32'h0, 0, 1);
    // misaligned accesses
    run_op(1'b0, 1'b0, 3'b010, 32'h06, 32'h0, 32'h12345678, 0, 0);
    check("lw_mis_pulses", n_mis, 32'd1);
    check("lw_mis_stall", n_stall, 32'd0);
    run_op(1'b1, 1'b0, 3'b001, 32'h03, 32'hFFFF, 32'h12345678, 0, 0);
    check("sh_mis_pulses", n_mis, 32'd1);
    run_op(1'b0, 1'b0, 3'b101, 32'h05, 32'h0, 32'h12345678, 0, 0);
    run_op(1'b0, 1'b0, 3'b000, 32'h07, 32'h0, 32'h12345678, 0, 0);
    check("lb_unaligned_ok_lit", got_data, 32'h00000012);
    // no-op requests
    req_valid_i = 1'b1; MemRead_i = 1'b0; MemWrite_i = 1'b0; addr_i = 32'h60;
    cycle_set(z0, 1'b1, 1'b0);
    req_valid_i = 1'b0; MemRead_i = 1'b1; funct3_i = 3'b010;
    cycle_set(z0, 1'b1, 1'b0);
    idle_cycle();

    // reset while WR is waiting on mem_ready_i
    req_valid_i = 1'b1; MemWrite_i = 1'b1; MemRead_i = 1'b0;
    funct3_i = 3'b010; addr_i = 32'h40; data_i = 32'h12345678;
    begin
      exp_t x;
      x = '0; x.stall = 1'b1;
      cycle_set(x, 1'b0, 1'b0);
      x = '0; x.stall = 1'b1; x.wr = 1'b1; x.addr = 32'h40; x.wdata = 32'h12345678;
      cycle_set(x, 1'b0, 1'b0);
    end
    chk_en = 1'b0;
    #2;
    rst_n_i = 1'b0;
    #1;
    check("rst_async_write", {31'd0, mem_write_o}, 32'd0);
    check("rst_async_stall", {31'd0, stall_o}, 32'd0);
    check("rst_async_addr", mem_addr_o, 32'd0);
    check("rst_async_wdata", mem_wdata_o, 32'd0);
    req_valid_i = 1'b0; MemWrite_i = 1'b0;
    e = '0;
    chk_en = 1'b1;
    @(negedge clk_i);
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    idle_cycle();
    run_op(1'b0, 1'b0, 3'b010, 32'h10, 32'h0, 32'hA5A5C3C3, 0, 0);
    check("lw_after_reset_lit", got_data, 32'hA5A5C3C3);
    check("lw_after_reset_stall", n_stall, 32'd2);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
